// File: rtl/proc_mem_pkg.sv
// Shared types and helpers for the processor-to-memory bridge: command, completion status,
// FSM state and the address alignment mask.
package proc_mem_pkg;

  localparam int unsigned CmdW     = 3;
  localparam int unsigned ErrW     = 2;
  localparam int unsigned MaxAddrW = 64;

  typedef enum logic [CmdW-1:0] {
    CmdNone   = 3'd0,
    CmdIfetch = 3'd1,
    CmdDread  = 3'd2,
    CmdDwrite = 3'd3,
    CmdFlush  = 3'd4
  } cmd_e;

  typedef enum logic [ErrW-1:0] {
    ErrOk      = 2'd0,
    ErrMem     = 2'd1,
    ErrTimeout = 2'd2,
    ErrBadCmd  = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } state_e;

  // Ones on every address bit that survives alignment, zeros on the forced-low bits.
  function automatic logic [MaxAddrW-1:0] align_mask(input int unsigned addr_w,
                                                     input int unsigned align_bits);
    logic [MaxAddrW-1:0] mask;
    for (int unsigned i = 0; i < MaxAddrW; i++) begin
      mask[i] = (i >= align_bits) && (i < addr_w);
    end
    return mask;
  endfunction

  function automatic logic is_reserved(input logic [CmdW-1:0] cmd);
    return cmd > CmdFlush;
  endfunction

endpackage

// File: rtl/proc_mem_bridge_if.sv
// Processor command port and memory request/response port of the bridge, bundled.
// The slave modport is the bridge's view; master is the processor/memory side.
interface proc_mem_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic [2:0]          proc_command;
  logic [ADDR_W-1:0]   proc_pc;
  logic [ADDR_W-1:0]   proc_data_addr;
  logic [DATA_W-1:0]   proc_wdata;
  logic [DATA_W/8-1:0] proc_wstrb;
  logic                proc_ready;
  logic [1:0]          proc_error;
  logic [DATA_W-1:0]   proc_rdata;

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [2:0]          mem_cmd;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_resp_data;
  logic                mem_resp_err;

  modport slave (
    input  proc_command, proc_pc, proc_data_addr, proc_wdata, proc_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
    output proc_ready, proc_error, proc_rdata,
    output mem_req_valid, mem_cmd, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output proc_command, proc_pc, proc_data_addr, proc_wdata, proc_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
    input  proc_ready, proc_error, proc_rdata,
    input  mem_req_valid, mem_cmd, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/proc_mem_req_buf.sv
// One-deep request register holding the command, aligned address, write data and strobes
// presented to memory. Clear takes priority over capture.
module proc_mem_req_buf
  import proc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                capture,
  input  logic [CmdW-1:0]     in_cmd,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [DATA_W/8-1:0] in_wstrb,
  output logic [CmdW-1:0]     cmd,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb
);

  logic [CmdW-1:0]     cmd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (capture) begin
      cmd_q   <= in_cmd;
      addr_q  <= in_addr;
      wdata_q <= in_wdata;
      wstrb_q <= in_wstrb;
    end
  end

  assign cmd   = cmd_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign wstrb = wstrb_q;

endmodule

// File: rtl/proc_mem_bridge.sv
// Registered bridge from the processor command port to a valid/ready memory interface,
// with a one-deep request buffer, response timeout and completion status reporting.
module proc_mem_bridge
  import proc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ALIGN_BITS = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  proc_mem_bridge_if.slave bus,
  output logic             busy
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned CntW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_W-1:0] AddrMask = ADDR_W'(align_mask(ADDR_W, ALIGN_BITS));

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              req_valid_q;
  logic              ready_q;
  logic              busy_q;
  err_e              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              cmd_reserved;
  logic              cmd_valid;
  logic              capture;
  logic              clear;
  logic              timeout_hit;
  logic              returns_data;
  logic [ADDR_W-1:0] cap_addr;
  logic [StrbW-1:0]  cap_wstrb;

  logic [CmdW-1:0]   buf_cmd;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic [StrbW-1:0]  buf_wstrb;

  always_comb begin
    cmd_reserved = is_reserved(bus.proc_command);
    cmd_valid    = (bus.proc_command != CmdNone) && !cmd_reserved;
    capture      = (state_q == StIdle) && cmd_valid;
    clear        = (state_q == StResp);
    cap_addr     = ((bus.proc_command == CmdIfetch) ? bus.proc_pc : bus.proc_data_addr) & AddrMask;
    cap_wstrb    = (bus.proc_command == CmdDwrite) ? bus.proc_wstrb : '0;
    // The cycle on which the counter would reach TIMEOUT is the last WAIT cycle.
    timeout_hit  = (int'(cnt_q) + 1) >= int'(TIMEOUT);
    returns_data = (buf_cmd == CmdIfetch) || (buf_cmd == CmdDread);
  end

  proc_mem_req_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .capture  (capture),
    .in_cmd   (bus.proc_command),
    .in_addr  (cap_addr),
    .in_wdata (bus.proc_wdata),
    .in_wstrb (cap_wstrb),
    .cmd      (buf_cmd),
    .addr     (buf_addr),
    .wdata    (buf_wdata),
    .wstrb    (buf_wstrb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      req_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= ErrOk;
      rdata_q     <= '0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_reserved) begin
            state_q <= StResp;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            err_q   <= ErrBadCmd;
            rdata_q <= '0;
          end else if (cmd_valid) begin
            state_q     <= StReq;
            req_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        StReq: begin
          if (bus.mem_req_ready) begin
            state_q     <= StWait;
            req_valid_q <= 1'b0;
            cnt_q       <= '0;
          end
        end
        StWait: begin
          // A response on the final cycle still wins over the timeout.
          if (bus.mem_resp_valid) begin
            state_q <= StResp;
            ready_q <= 1'b1;
            err_q   <= bus.mem_resp_err ? ErrMem : ErrOk;
            rdata_q <= (returns_data && !bus.mem_resp_err) ? bus.mem_resp_data : '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (timeout_hit) begin
              state_q <= StResp;
              ready_q <= 1'b1;
              err_q   <= ErrTimeout;
              rdata_q <= '0;
            end
          end
        end
        StResp: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_cmd       = buf_cmd;
  assign bus.mem_addr      = buf_addr;
  assign bus.mem_wdata     = buf_wdata;
  assign bus.mem_wstrb     = buf_wstrb;
  assign bus.proc_ready    = ready_q;
  assign bus.proc_error    = err_q;
  assign bus.proc_rdata    = rdata_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_proc_mem_bridge.sv
// Directed bench for proc_mem_bridge: a transaction-level model derives the expected
// per-cycle outputs and a negedge process compares them against the bridge.
module tb_proc_mem_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned AB = 2;
  localparam int          TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  always #5 clk = ~clk;

  proc_mem_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  proc_mem_bridge #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .ALIGN_BITS (AB),
    .TIMEOUT    (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic        chk_en = 1'b0;
  logic        exp_busy, exp_req_valid, exp_ready, exp_fields;
  logic [2:0]  exp_cmd;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_wstrb;
  logic [1:0]  exp_error;
  logic [1:0]  last_err   = 2'd0;
  logic [31:0] last_rdata = 32'd0;

  int          cyc;
  int          obs_ready_cycle;
  int          obs_req_seen;
  logic [31:0] obs_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("mem_req_valid", 64'(bus.mem_req_valid), 64'(exp_req_valid));
      chk("proc_ready", 64'(bus.proc_ready), 64'(exp_ready));
      chk("proc_error", 64'(bus.proc_error), 64'(exp_error));
      chk("proc_rdata", 64'(bus.proc_rdata), 64'(exp_rdata));
      if (exp_fields) begin
        chk("mem_cmd", 64'(bus.mem_cmd), 64'(exp_cmd));
        chk("mem_addr", 64'(bus.mem_addr), 64'(exp_addr));
        chk("mem_wdata", 64'(bus.mem_wdata), 64'(exp_wdata));
        chk("mem_wstrb", 64'(bus.mem_wstrb), 64'(exp_wstrb));
      end
    end
    if (bus.mem_req_valid) begin
      if (obs_req_seen == 0) obs_addr = bus.mem_addr;
      obs_req_seen++;
    end
    if (bus.proc_ready && obs_ready_cycle < 0) obs_ready_cycle = cyc;
  end

  task automatic exp_idle();
    exp_busy = 1'b0; exp_req_valid = 1'b0; exp_ready = 1'b0; exp_fields = 1'b0;
    exp_error = last_err; exp_rdata = last_rdata;
  endtask

  task automatic exp_req(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    exp_busy = 1'b1; exp_req_valid = 1'b1; exp_ready = 1'b0; exp_fields = 1'b1;
    exp_cmd = c; exp_addr = a; exp_wdata = d; exp_wstrb = s;
    exp_error = last_err; exp_rdata = last_rdata;
  endtask

  task automatic exp_wait();
    exp_busy = 1'b1; exp_req_valid = 1'b0; exp_ready = 1'b0; exp_fields = 1'b0;
    exp_error = last_err; exp_rdata = last_rdata;
  endtask

  task automatic exp_resp(input logic [1:0] e, input logic [31:0] r);
    last_err = e; last_rdata = r;
    exp_busy = 1'b1; exp_req_valid = 1'b0; exp_ready = 1'b1; exp_fields = 1'b0;
    exp_error = e; exp_rdata = r;
  endtask

  task automatic mem_quiet();
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_err = 1'b0;
    bus.mem_resp_data = $urandom;
  endtask

  // resp_delay counts empty WAIT cycles before the response; >= TO means no response at all.
  task automatic run_txn(input logic [2:0] cmd, input logic [31:0] pc, input logic [31:0] daddr,
                         input logic [31:0] wdata, input logic [3:0] wstrb, input int stall,
                         input int resp_delay, input logic [31:0] resp_data, input logic resp_err);
    logic        reserved;
    logic [31:0] m_addr, m_rdata;
    logic [3:0]  m_strb;
    logic [1:0]  m_err;
    int          wait_cycles, resp_at, w;
    reserved = cmd >= 3'd5;
    m_addr   = (cmd == 3'd1 ? pc : daddr) & ~((32'd1 << AB) - 32'd1);
    m_strb   = (cmd == 3'd3) ? wstrb : 4'h0;
    if (resp_delay < TO) begin
      wait_cycles = resp_delay + 1;
      m_err       = resp_err ? 2'd1 : 2'd0;
    end else begin
      wait_cycles = TO;
      m_err       = 2'd2;
    end
    if (reserved) m_err = 2'd3;
    m_rdata = (m_err == 2'd0 && (cmd == 3'd1 || cmd == 3'd2)) ? resp_data : 32'd0;
    resp_at = reserved ? 1 : 2 + stall + wait_cycles;
    obs_ready_cycle = -1;
    obs_req_seen    = 0;
    for (int c = 0; c <= resp_at + 1; c++) begin
      @(posedge clk); #1;
      cyc = c;
      mem_quiet();
      if (c == 0) begin
        bus.proc_command = cmd; bus.proc_pc = pc; bus.proc_data_addr = daddr;
        bus.proc_wdata = wdata; bus.proc_wstrb = wstrb;
        exp_idle();
      end else if (c > resp_at) begin
        bus.proc_command = 3'd0;
        exp_idle();
      end else if (c == resp_at) begin
        exp_resp(m_err, m_rdata);
      end else if (c <= 1 + stall) begin
        exp_req(cmd, m_addr, wdata, m_strb);
        bus.mem_req_ready = (c == 1 + stall);
        if (c < 1 + stall) begin
          // Stray response and moving processor inputs while the request is held.
          bus.mem_resp_valid = 1'b1;
          bus.proc_pc = $urandom; bus.proc_data_addr = $urandom;
          bus.proc_wdata = $urandom; bus.proc_wstrb = 4'($urandom);
        end
      end else begin
        exp_wait();
        bus.proc_command = 3'd4;
        w = c - (1 + stall);
        if (resp_delay < TO && w == resp_delay + 1) begin
          bus.mem_resp_valid = 1'b1; bus.mem_resp_data = resp_data; bus.mem_resp_err = resp_err;
        end
      end
    end
  endtask

  task automatic idle_cycles(input int n, input logic stray);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mem_quiet();
      bus.mem_resp_valid = stray;
      exp_idle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.proc_command = 3'd0; bus.proc_pc = '0; bus.proc_data_addr = '0;
    bus.proc_wdata = '0; bus.proc_wstrb = '0;
    mem_quiet();
    obs_ready_cycle = -1; obs_req_seen = 0; obs_addr = '0; cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_req(3'd0, 32'd0, 32'd0, 4'd0);
    exp_busy = 1'b0; exp_req_valid = 1'b0;
    chk_en = 1'b1;
    idle_cycles(1, 1'b0);

    // DREAD at minimum latency
    run_txn(3'd2, 32'hAAAA_0000, 32'h0000_1007, 32'h5555_0000, 4'hF, 0, 0, 32'hDEAD_BEEF, 1'b0);
    chk("dread_latency", 64'(obs_ready_cycle), 64'd3);
    chk("dread_addr", 64'(obs_addr), 64'h0000_1004);
    chk("dread_rdata", 64'(bus.proc_rdata), 64'hDEAD_BEEF);

    // DWRITE with 5 stalled request cycles
    run_txn(3'd3, 32'h1111_0000, 32'h0000_2002, 32'h1234_5678, 4'b0011, 5, 2, 32'hCAFE_F00D,
            1'b0);
    chk("dwrite_req_cycles", 64'(obs_req_seen), 64'd6);
    chk("dwrite_rdata", 64'(bus.proc_rdata), 64'd0);

    // IFETCH timing out, then a late response that must be ignored
    run_txn(3'd1, 32'h0000_0403, 32'h0000_9000, 32'd0, 4'h0, 0, 99, 32'h7777_7777, 1'b0);
    chk("timeout_latency", 64'(obs_ready_cycle), 64'd6);
    chk("timeout_error", 64'(bus.proc_error), 64'd2);
    chk("ifetch_addr", 64'(obs_addr), 64'h0000_0400);
    idle_cycles(3, 1'b1);

    // Reserved command: immediate BAD_CMD, no memory request
    run_txn(3'd6, 32'd0, 32'h0000_4000, 32'd0, 4'hF, 0, 0, 32'd0, 1'b0);
    chk("badcmd_latency", 64'(obs_ready_cycle), 64'd1);
    chk("badcmd_no_req", 64'(obs_req_seen), 64'd0);

    // Error response on the same cycle as the timeout limit
    run_txn(3'd2, 32'd0, 32'h0000_5008, 32'd0, 4'h0, 1, TO - 1, 32'h0F0F_0F0F, 1'b1);
    chk("limit_err_wins", 64'(bus.proc_error), 64'd1);

    // Successful IFETCH, FLUSH and an errored DREAD
    run_txn(3'd1, 32'h8000_0011, 32'h0000_0000, 32'd0, 4'h0, 0, 1, 32'h0BAD_F00D, 1'b0);
    chk("ifetch_rdata", 64'(bus.proc_rdata), 64'h0BAD_F00D);
    run_txn(3'd4, 32'd0, 32'h0000_6003, 32'h9999_9999, 4'hF, 2, 0, 32'h1357_9BDF, 1'b0);
    run_txn(3'd2, 32'd0, 32'h0000_700C, 32'd0, 4'h0, 0, 0, 32'h2468_ACE0, 1'b1);

    // Reset during WAIT; the following response must produce nothing
    @(posedge clk); #1;
    cyc = 0; mem_quiet(); exp_idle();
    bus.proc_command = 3'd2; bus.proc_data_addr = 32'h0000_3001; bus.proc_wdata = 32'h0;
    @(posedge clk); #1;
    mem_quiet(); bus.mem_req_ready = 1'b1;
    exp_req(3'd2, 32'h0000_3000, 32'h0, 4'h0);
    @(posedge clk); #1;
    mem_quiet(); exp_wait();
    @(posedge clk); #1;
    mem_quiet(); exp_wait(); rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; bus.proc_command = 3'd0;
    mem_quiet(); bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hFEED_FACE;
    last_err = 2'd0; last_rdata = 32'd0;
    exp_req(3'd0, 32'd0, 32'd0, 4'd0);
    exp_busy = 1'b0; exp_req_valid = 1'b0;
    idle_cycles(3, 1'b0);
    chk("post_reset_rdata", 64'(bus.proc_rdata), 64'd0);

    // Normal operation resumes after the reset
    run_txn(3'd2, 32'd0, 32'h0000_0ABC, 32'd0, 4'h0, 0, 0, 32'hA5A5_5A5A, 1'b0);
    chk("resume_latency", 64'(obs_ready_cycle), 64'd3);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
